// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and ALU operand forwarding selects
package hazard_pkg;
    typedef enum logic {RUN, STALL} state_t;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// forward_unit: picks the newest producer of one EX source register, never x0
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd
);
    assign fwd = (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs) ? FWD_MEM :
                 (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / taken-branch flush control plus operand forwarding
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);
    state_t     state, state_nx;
    logic [1:0] stall_cnt, cnt_nx;
    logic       load_use;

    assign load_use = ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

    // The detection cycle is the first stall cycle, so STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_nx   = state;
        cnt_nx     = stall_cnt;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nx   = RUN;
            cnt_nx     = 2'd0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nx   = RUN;
            cnt_nx     = 2'd0;
        end else if (state == STALL) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nx   = (stall_cnt <= 2'd1) ? RUN : STALL;
            cnt_nx     = (stall_cnt <= 2'd1) ? 2'd0 : stall_cnt - 2'd1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nx   = (LOAD_LAT > 1) ? STALL : RUN;
            cnt_nx     = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 1) : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
        end else begin
            state     <= state_nx;
            stall_cnt <= cnt_nx;
        end
    end

    forward_unit u_fwd_a (
        .ex_rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .fwd(fwd_a)
    );

    forward_unit u_fwd_b (
        .ex_rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .fwd(fwd_b)
    );

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pc_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (ifid_flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three hazard_ctrl instances (LOAD_LAT 1,3,4) on shared stimulus,
// scoreboarded against a remaining-stall-cycles reference model.
module tb_hazard_ctrl;
    typedef struct packed {
        logic r, br, mr;
        logic [4:0] erd, irs1, irs2, ers1, ers2, mrd;
        logic mw;
        logic [4:0] wrd;
        logic ww;
    } stim_t;

    typedef struct {
        bit pc_en, ifid_en, ifid_flush, idex_flush, known;
        int fa, fb, sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic ex_memread = 1'b0, ex_branch_taken = 1'b0, mem_regwrite = 1'b0, wb_regwrite = 1'b0;

    logic        pc_en_o[3], ifid_en_o[3], ifid_flush_o[3], idex_flush_o[3];
    logic [1:0]  fa_o[3], fb_o[3];
    logic [15:0] sc_o[3], fc_o[3];

    int   lat[3] = '{1, 3, 4};
    exp_t q[3][$];
    int   remain[3], sc[3], fc[3];
    bit   known = 1'b0;
    bit   done = 1'b0;
    int   checks = 0, fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : lane
        hazard_ctrl #(.LOAD_LAT(g == 0 ? 1 : g == 1 ? 3 : 4)) dut (
            .clk(clk), .rst(rst),
            .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
            .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
            .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
            .pc_en(pc_en_o[g]), .ifid_en(ifid_en_o[g]), .ifid_flush(ifid_flush_o[g]),
            .idex_flush(idex_flush_o[g]), .fwd_a(fa_o[g]), .fwd_b(fb_o[g]),
            .stall_cycles(sc_o[g]), .flush_count(fc_o[g])
        );
    end

    function automatic int fwd_of(logic [4:0] rs, stim_t s);
        if (rs == 0) return 0;
        if (s.mw && s.mrd == rs) return 2;
        if (s.ww && s.wrd == rs) return 1;
        return 0;
    endfunction

    // Reference: a taken branch wins, then any owed stall cycles, then a fresh load-use.
    function automatic void predict(stim_t s);
        bit lu = s.mr && s.erd != 0 && (s.erd == s.irs1 || s.erd == s.irs2);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
`ifdef HAZARD_PERF_EN
            e.known = known;
            e.sc = sc[k];
            e.fc = fc[k];
`else
            e.known = 1'b1;
            e.sc = 0;
            e.fc = 0;
`endif
            if (s.r) begin
                {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush} = 4'b0011;
                remain[k] = 0;
                sc[k] = 0;
                fc[k] = 0;
            end else begin
                if (s.br) begin
                    {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush} = 4'b1111;
                    remain[k] = 0;
                end else if (remain[k] > 0) begin
                    {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush} = 4'b0001;
                    remain[k]--;
                end else if (lu) begin
                    {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush} = 4'b0001;
                    remain[k] = lat[k] - 1;
                end else begin
                    {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush} = 4'b1100;
                end
                if (!e.pc_en && sc[k] < 65535) sc[k]++;
                if (e.ifid_flush && fc[k] < 65535) fc[k]++;
            end
            e.fa = fwd_of(s.ers1, s);
            e.fb = fwd_of(s.ers2, s);
            q[k].push_back(e);
        end
        if (s.r) known = 1'b1;
    endfunction

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        rst = s.r; ex_branch_taken = s.br; ex_memread = s.mr; ex_rd = s.erd;
        id_rs1 = s.irs1; id_rs2 = s.irs2; ex_rs1 = s.ers1; ex_rs2 = s.ers2;
        mem_rd = s.mrd; mem_regwrite = s.mw; wb_rd = s.wrd; wb_regwrite = s.ww;
        predict(s);
    endtask

    function automatic stim_t load_use5();
        stim_t s = '0;
        s.mr = 1'b1;
        s.erd = 5'd5;
        s.irs2 = 5'd5;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = '0;
        s.r = 1'b1;
        repeat (2) step(s);
        s = '0;
        s.mrd = 5'd7; s.wrd = 5'd7; s.mw = 1'b1; s.ww = 1'b1; s.ers1 = 5'd7;
        step(s);
        s.mw = 1'b0;
        step(s);
        s.ers1 = 5'd0;
        step(s);
        s = '0;
        s.mr = 1'b1;
        step(s);
        step(load_use5());
        s = '0;
        repeat (5) step(s);
        step(load_use5());
        step(s);
        s.br = 1'b1;
        step(s);
        s.br = 1'b0;
        repeat (3) step(s);
        step(load_use5());
        step(s);
        s.r = 1'b1;
        step(s);
        s.r = 1'b0;
        repeat (2) step(s);
        repeat (3000) begin
            s.r = ($urandom % 64) == 0;
            s.br = ($urandom % 10) == 0;
            s.mr = ($urandom % 3) == 0;
            s.erd = 5'($urandom % 8); s.irs1 = 5'($urandom % 8); s.irs2 = 5'($urandom % 8);
            s.ers1 = 5'($urandom % 8); s.ers2 = 5'($urandom % 8);
            s.mrd = 5'($urandom % 8); s.wrd = 5'($urandom % 8);
            s.mw = 1'($urandom); s.ww = 1'($urandom);
            step(s);
        end
        repeat (2) @(posedge clk);
        done = 1'b1;
    end

    function automatic void chk(string name, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s lane%0d (LOAD_LAT=%0d): got %0d expected %0d", name, k, lat[k], act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (q[k].size() > 0) begin
                    e = q[k].pop_front();
                    chk("pc_en", k, int'(pc_en_o[k]), int'(e.pc_en));
                    chk("ifid_en", k, int'(ifid_en_o[k]), int'(e.ifid_en));
                    chk("ifid_flush", k, int'(ifid_flush_o[k]), int'(e.ifid_flush));
                    chk("idex_flush", k, int'(idex_flush_o[k]), int'(e.idex_flush));
                    chk("fwd_a", k, int'(fa_o[k]), e.fa);
                    chk("fwd_b", k, int'(fb_o[k]), e.fb);
                    if (e.known) begin
                        chk("stall_cycles", k, int'(sc_o[k]), e.sc);
                        chk("flush_count", k, int'(fc_o[k]), e.fc);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) chk("scoreboard_drain", k, q[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: LOAD_LAT, 1, number of stall cycles inserted per load-use hazard (legal 1..4).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
REQ-005 SHALL have ports: ex_rs1, ex_rs2  in  5 each  source registers of the instruction in execute.
REQ-006 SHALL have ports: ex_rd  in  5, ex_memread  in  1 (lbu in execute), ex_branch_taken  in  1 (bne resolved taken).
REQ-007 SHALL have ports: mem_rd  in  5, mem_regwrite  in  1, wb_rd  in  5, wb_regwrite  in  1.
REQ-008 SHALL have ports: pc_en, ifid_en, ifid_flush, idex_flush  out  1 each  pipeline register controls.
REQ-009 SHALL have ports: fwd_a, fwd_b  out  2 each  ALU operand source select: 00 regfile, 10 MEM result, 01 WB result.
REQ-010 SHALL have ports: stall_cycles, flush_count  out  16 each  performance counters.

Function
REQ-011 SHALL implement FSM states RUN and STALL, plus a 2-bit down-counter stall_cnt.
REQ-012 SHALL detect load-use when ex_memread=1, ex_rd!=0 and ex_rd equals id_rs1 or id_rs2.
REQ-013 SHALL, in RUN with load-use, drive pc_en=0, ifid_en=0, idex_flush=1 in the same cycle (combinational).
REQ-014 SHALL, on that detection, go to STALL with stall_cnt=LOAD_LAT-1 if LOAD_LAT>1, else stay in RUN.
REQ-015 SHALL, in STALL, drive pc_en=0, ifid_en=0, idex_flush=1, decrement stall_cnt each cycle, and return to RUN after the cycle in which stall_cnt=0.
REQ-016 SHALL, on ex_branch_taken=1 in any state, drive ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1 and go to RUN with stall_cnt=0 next cycle.
REQ-017 SHALL give ex_branch_taken priority over load-use and STALL when both are asserted in the same cycle.
REQ-018 SHALL, with no hazard in RUN, drive pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0.
REQ-019 SHALL set fwd_a=10 when mem_regwrite=1, mem_rd!=0 and mem_rd=ex_rs1.
REQ-020 SHALL otherwise set fwd_a=01 when wb_regwrite=1, wb_rd!=0 and wb_rd=ex_rs1; else 00.
REQ-021 SHALL compute fwd_b identically against ex_rs2, with MEM taking priority over WB.
REQ-022 SHALL never forward or stall on register x0.
REQ-023 SHALL produce forwarding selects combinationally, independent of FSM state.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state=RUN, stall_cnt=0 and both counters=0, including when a stall is in progress.
REQ-025 SHALL drive pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1 in any cycle where rst=1.

Configuration
REQ-026 SHALL, with HAZARD_PERF_EN defined, increment stall_cycles once per cycle with pc_en=0 and flush_count once per cycle with ifid_flush=1 (excluding reset cycles), each saturating at 16'hFFFF.
REQ-027 SHALL, without HAZARD_PERF_EN, keep stall_cycles and flush_count ports present and tied to 0, with no counter flops.

Structure
REQ-028 SHALL take the state enum (RUN, STALL) and the forwarding-select constants (FWD_RF, FWD_MEM, FWD_WB) from shared package hazard_pkg.
REQ-029 SHALL place the forwarding logic in sub-module forward_unit, instanced once per operand (a and b).

Verification
REQ-030 SHALL verify load-use: LOAD_LAT=1, ex_memread=1, ex_rd=5, id_rs2=5 -> exactly 1 cycle with pc_en=0, idex_flush=1, then RUN.
REQ-031 SHALL verify multi-cycle stall: LOAD_LAT=3, same stimulus -> 3 consecutive cycles with pc_en=0; with HAZARD_PERF_EN, stall_cycles=3.
REQ-032 SHALL verify branch priority: ex_branch_taken=1 in the 2nd STALL cycle (LOAD_LAT=3) -> ifid_flush=1, idex_flush=1, pc_en=1, and RUN next cycle.
REQ-033 SHALL verify forwarding: mem_rd=7 and wb_rd=7, both regwrite=1, ex_rs1=7 -> fwd_a=10; with mem_regwrite=0 -> fwd_a=01; with ex_rs1=0 -> fwd_a=00.
REQ-034 SHALL verify x0 handling: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall (pc_en=1).
REQ-035 SHALL verify mid-stall reset: rst=1 during STALL (LOAD_LAT=4) -> next cycle RUN, counters 0, pc_en=1 when rst=0 and there is no hazard.
